// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU byte protocol: opcodes, sequencer
// state encoding and per-opcode byte counts.
package alu_pkg;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_MUL = 2'b10;
  localparam logic [1:0] ALU_OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEGIN,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } alu_drv_state_t;

  // Division carries a 16-bit dividend plus a divisor byte.
  function automatic logic [1:0] n_operands(input logic [1:0] op);
    return (op == ALU_OP_DIV) ? 2'd3 : 2'd2;
  endfunction

  // Add/sub return a single byte; mul/div return two.
  function automatic logic [1:0] n_results(input logic [1:0] op);
    return ((op == ALU_OP_ADD) || (op == ALU_OP_SUB)) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/alu_drv_watchdog.sv
// Load/enable cycle counter for the WAIT-state watchdog; expired is high on
// the LIMIT-th enabled cycle after a load.
module alu_drv_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_reg;

  assign expired = en && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (en && !expired) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_driver.sv
// Host-side sequencer: serialises one ALU operation onto begin/in/op and
// gathers the result bytes. Watchdog enabled by ALU_SEQ_DRIVER_TIMEOUT_EN.
module alu_seq_driver
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  opnd_a,
  input  logic [7:0]  opnd_b,
  input  logic [7:0]  opnd_c,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [1:0]  alu_op,
  output logic        alu_begin,
  output logic [7:0]  alu_in,
  input  logic [7:0]  alu_out,
  input  logic        alu_end
);

  alu_drv_state_t state_reg, state_next;
  logic [1:0]  op_reg, op_next;
  logic [7:0]  a_reg, a_next, b_reg, b_next, c_reg, c_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [7:0]  byte0_reg, byte0_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [15:0] result_reg, result_next;
  logic        begin_reg, begin_next;
  logic [7:0]  in_reg, in_next;
  logic        timeout_hit;

`ifdef ALU_SEQ_DRIVER_TIMEOUT_EN
  logic wd_load;
  logic wd_en;

  assign wd_load = (state_next == ST_WAIT) && (state_reg != ST_WAIT);
  assign wd_en   = (state_reg == ST_WAIT);

  alu_drv_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wd_load),
    .en      (wd_en),
    .expired (timeout_hit)
  );
`else
  // No watchdog in this build: WAIT never times out.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      cnt_reg    <= '0;
      byte0_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      result_reg <= '0;
      begin_reg  <= 1'b0;
      in_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      c_reg      <= c_next;
      cnt_reg    <= cnt_next;
      byte0_reg  <= byte0_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      result_reg <= result_next;
      begin_reg  <= begin_next;
      in_reg     <= in_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    c_next      = c_reg;
    cnt_next    = cnt_reg;
    byte0_next  = byte0_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    result_next = result_reg;
    begin_next  = 1'b0;
    in_next     = in_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          op_next    = op;
          a_next     = opnd_a;
          b_next     = opnd_b;
          c_next     = opnd_c;
          busy_next  = 1'b1;
          begin_next = 1'b1;
          in_next    = 8'h00;
          state_next = ST_BEGIN;
        end
      end
      ST_BEGIN: begin
        in_next    = a_reg;
        cnt_next   = 2'd1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        // cnt_reg is the number of bytes already on the bus, including this one.
        if (cnt_reg == n_operands(op_reg)) begin
          in_next    = 8'h00;
          state_next = ST_WAIT;
        end else begin
          in_next  = (cnt_reg == 2'd1) ? b_reg : c_reg;
          cnt_next = cnt_reg + 2'd1;
        end
      end
      ST_WAIT: begin
        if (alu_end) begin
          byte0_next = alu_out;
          // Single-byte results finish here so add/sub keep the 5-cycle latency.
          if (n_results(op_reg) == 2'd1) begin
            result_next = {8'h00, alu_out};
            done_next   = 1'b1;
            state_next  = ST_DONE;
          end else begin
            state_next = ST_RECV;
          end
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_RECV: begin
        // A dropped alu_end means the second byte never came; it reads as zero.
        result_next = {byte0_reg, alu_end ? alu_out : 8'h00};
        done_next   = 1'b1;
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign result    = result_reg;
  assign alu_op    = op_reg;
  assign alu_begin = begin_reg;
  assign alu_in    = in_reg;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver; the ALU is stubbed by driving alu_end/alu_out
// from the stimulus sequence. Timeout checks follow ALU_SEQ_DRIVER_TIMEOUT_EN.
module tb_alu_seq_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  opnd_a = 8'h00;
  logic [7:0]  opnd_b = 8'h00;
  logic [7:0]  opnd_c = 8'h00;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic [1:0]  alu_op;
  logic        alu_begin;
  logic [7:0]  alu_in;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_end = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_begin  = 0;
  int n_done   = 0;
  int snap;

  alu_seq_driver #(
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .opnd_a    (opnd_a),
    .opnd_b    (opnd_b),
    .opnd_c    (opnd_c),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .alu_op    (alu_op),
    .alu_begin (alu_begin),
    .alu_in    (alu_in),
    .alu_out   (alu_out),
    .alu_end   (alu_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (alu_begin === 1'b1) n_begin++;
    if (done === 1'b1) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
    op = o; opnd_a = a; opnd_b = b; opnd_c = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_result", result, 16'h0000);
    chk("rst_begin", 16'(alu_begin), 16'h0);
    chk("rst_in", 16'(alu_in), 16'h0);
    chk("rst_op", 16'(alu_op), 16'h0);
    #2 rst_n = 1'b1;
    tick();

    // Add 0x02 + 0x03
    snap = n_begin;
    issue(2'b00, 8'h02, 8'h03, 8'h00);
    chk("add_begin", 16'(alu_begin), 16'h1);
    chk("add_busy", 16'(busy), 16'h1);
    chk("add_in_begin", 16'(alu_in), 16'h00);
    tick();
    chk("add_begin_low", 16'(alu_begin), 16'h0);
    chk("add_in_a", 16'(alu_in), 16'h02);
    tick();
    chk("add_in_b", 16'(alu_in), 16'h03);
    tick();
    chk("add_in_wait", 16'(alu_in), 16'h00);
    alu_end = 1'b1; alu_out = 8'h05;
    tick();
    alu_end = 1'b0;
    chk("add_done", 16'(done), 16'h1);
    chk("add_result", result, 16'h0005);
    chk("add_busy_at_done", 16'(busy), 16'h1);
    tick();
    chk("add_done_low", 16'(done), 16'h0);
    chk("add_busy_low", 16'(busy), 16'h0);
    chk("add_one_begin", 16'(n_begin - snap), 16'd1);
    $display("txn add a=02 b=03 result=%h", result);

    // Mul 0xC5 x 0x04 with two wait cycles before the result
    issue(2'b10, 8'hC5, 8'h04, 8'h00);
    tick();
    chk("mul_in_a", 16'(alu_in), 16'hC5);
    tick();
    chk("mul_in_b", 16'(alu_in), 16'h04);
    tick(); tick(); tick();
    chk("mul_busy_wait", 16'(busy), 16'h1);
    alu_end = 1'b1; alu_out = 8'h03;
    tick();
    chk("mul_busy_recv", 16'(busy), 16'h1);
    chk("mul_no_early_done", 16'(done), 16'h0);
    alu_out = 8'h14;
    tick();
    alu_end = 1'b0;
    chk("mul_done", 16'(done), 16'h1);
    chk("mul_result", result, 16'h0314);
    chk("mul_busy_at_done", 16'(busy), 16'h1);
    tick();
    chk("mul_busy_low", 16'(busy), 16'h0);
    $display("txn mul a=c5 b=04 result=%h", result);

    // Div 0x3112 / 0x7B, with start re-asserted mid-SEND
    snap = n_begin;
    issue(2'b11, 8'h31, 8'h12, 8'h7B);
    tick();
    chk("div_in_a", 16'(alu_in), 16'h31);
    op = 2'b00; opnd_a = 8'hFF; opnd_b = 8'hEE; opnd_c = 8'hDD; start = 1'b1;
    tick();
    chk("div_in_b", 16'(alu_in), 16'h12);
    tick();
    start = 1'b0;
    chk("div_in_c", 16'(alu_in), 16'h7B);
    chk("div_op_held", 16'(alu_op), 16'h3);
    tick();
    chk("div_in_wait", 16'(alu_in), 16'h00);
    alu_end = 1'b1; alu_out = 8'h66;
    tick();
    alu_out = 8'h10;
    tick();
    alu_end = 1'b0;
    chk("div_done", 16'(done), 16'h1);
    chk("div_result", result, 16'h6610);
    tick();
    chk("div_one_begin", 16'(n_begin - snap), 16'd1);
    chk("div_idle_after", 16'(busy), 16'h0);
    $display("txn div a=31 b=12 c=7b result=%h", result);

    // Mul with alu_end dropping after the first byte
    issue(2'b10, 8'h11, 8'h22, 8'h00);
    tick(); tick(); tick();
    alu_end = 1'b1; alu_out = 8'hAB;
    tick();
    alu_end = 1'b0; alu_out = 8'h77;
    tick();
    chk("short_done", 16'(done), 16'h1);
    chk("short_result", result, 16'hAB00);
    tick();
    $display("txn mul-short result=%h", result);

    // alu_end while idle is ignored
    snap = n_done;
    alu_end = 1'b1; alu_out = 8'h99;
    tick(); tick();
    alu_end = 1'b0;
    tick();
    chk("idle_end_busy", 16'(busy), 16'h0);
    chk("idle_end_done", 16'(n_done - snap), 16'd0);
    chk("idle_end_result", result, 16'hAB00);
    $display("txn idle-alu_end result=%h", result);

    // Reset asserted during RECV aborts without done
    issue(2'b10, 8'hC5, 8'h04, 8'h00);
    tick(); tick(); tick();
    alu_end = 1'b1; alu_out = 8'h03;
    tick();
    alu_end = 1'b0;
    snap = n_done;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_result", result, 16'h0000);
    chk("abort_op", 16'(alu_op), 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("abort_no_done", 16'(n_done - snap), 16'd0);
    $display("txn reset-abort busy=%b result=%h", busy, result);

    // Add after reset
    issue(2'b00, 8'h10, 8'h20, 8'h00);
    tick(); tick(); tick();
    alu_end = 1'b1; alu_out = 8'h30;
    tick();
    alu_end = 1'b0;
    chk("post_rst_done", 16'(done), 16'h1);
    chk("post_rst_result", result, 16'h0030);
    tick();
    $display("txn add a=10 b=20 result=%h", result);

    // Timeout behaviour: ALU never answers
    issue(2'b00, 8'h01, 8'h01, 8'h00);
    tick(); tick(); tick();
`ifdef ALU_SEQ_DRIVER_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("tmo_no_err_yet", 16'(err), 16'h0);
    end
    tick();
    chk("tmo_err", 16'(err), 16'h1);
    chk("tmo_busy", 16'(busy), 16'h0);
    chk("tmo_result", result, 16'h0030);
    tick();
    chk("tmo_err_pulse", 16'(err), 16'h0);
    $display("txn timeout err seen busy=%b result=%h", busy, result);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("wait_no_err", 16'(err), 16'h0);
    chk("wait_busy", 16'(busy), 16'h1);
    chk("wait_in", 16'(alu_in), 16'h00);
    $display("txn no-watchdog still waiting busy=%b", busy);
    #2 rst_n = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_driver.md
# alu_seq_driver

Host-side sequencer for the serial ALU byte protocol. It accepts a complete operation in one parallel handshake (`op` plus up to three operand bytes) and serialises it onto the ALU's `begin`/`in`/`op` bus. It then collects the result bytes that arrive while the ALU's `end` is high and returns them as one parallel result with a done pulse. It sits between the control/register logic and the `alu` instance, acting as the initiating end of the interface the ALU responds to.

## Interface
- `TIMEOUT_CYC`, default 64: cycles allowed between the last operand byte and the first `alu_end`. Used only with the watchdog.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only in IDLE.
- `op` input 2: 00 add, 01 sub, 10 mul, 11 div.
- `opnd_a` input 8: first operand byte. For div, dividend high byte.
- `opnd_b` input 8: second operand byte. For div, dividend low byte.
- `opnd_c` input 8: div only, divisor.
- `busy` output 1: high from the accepted `start` until `done`/`err`.
- `done` output 1: one-cycle pulse; `result` is valid.
- `err` output 1: one-cycle pulse on watchdog timeout.
- `result` output 16: add/sub use {8'h00, byte0}; mul/div use {byte0, byte1}.
- `alu_op` output 2: to ALU; held stable while `busy`.
- `alu_begin` output 1: to ALU; one-cycle pulse.
- `alu_in` output 8: to ALU; operand bytes.
- `alu_out` input 8: from ALU.
- `alu_end` input 1: from ALU; a result byte is valid on `alu_out`.

## Operation
- States: IDLE → BEGIN → SEND → WAIT → RECV → DONE → IDLE.
- IDLE: when `start`=1, register `op` and all operands, set `busy`, go to BEGIN. `start` while `busy` is ignored and not queued.
- BEGIN: drive `alu_begin`=1 for exactly one cycle; `alu_in`=0.
- SEND: present one byte per cycle in order a, b, (c).
  - Byte count is 2 for op 00/01/10 and 3 for op 11.
  - A 2-bit counter tracks the bytes. After the last byte, go to WAIT.
- WAIT: `alu_in` returns to 0. Go to RECV on the first cycle with `alu_end`=1, capturing that cycle's byte as byte0.
- RECV: capture one byte per cycle while `alu_end`=1.
  - Expected byte count is 1 for op 00/01 and 2 for op 10/11.
  - On reaching the expected count, go to DONE.
  - If `alu_end` drops early, the missing bytes read as 0 and the block goes to DONE.
- DONE: `done`=1 for one cycle, `busy`=0 on the next cycle, return to IDLE. `result` holds its value until the next `done`.
- Extra `alu_end` cycles seen while in IDLE are ignored.
- Reset values: `busy`=0, `done`=0, `err`=0, `result`=0, `alu_begin`=0, `alu_in`=0, `alu_op`=0, state=IDLE.
- `rst_n` low at any point aborts the transfer immediately. No `done` or `err` is issued for the aborted operation.

## Timing
- `start` at edge N (sampled in IDLE):
  - `alu_begin` is high during cycle N+1.
  - `opnd_a` is on `alu_in` in cycle N+2, `opnd_b` in N+3, `opnd_c` in N+4 (div only).
- An `alu_end` seen in the same cycle the last byte is driven is not valid. WAIT starts sampling one cycle after the last byte.
- `done` is high in the cycle after the last result byte is captured.
- Minimum add latency is `start` → `done` = 5 cycles, plus the ALU compute time.
- All outputs are registered. No combinational path exists from `alu_out`/`alu_end` to the host outputs.

## Configuration
- `ALU_SEQ_DRIVER_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT.
  - On reaching `TIMEOUT_CYC` with no `alu_end`: `err` pulses for one cycle, `result` is unchanged, `busy` drops, and the state returns to IDLE.
- Undefined: there is no counter, WAIT lasts indefinitely, and `err` is tied to 0.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `ALU_OP_ADD`, `ALU_OP_SUB`, `ALU_OP_MUL`, `ALU_OP_DIV`.
  - State enum typedef.
  - Functions `n_operands(op)` and `n_results(op)`.
- One sub-module, `alu_drv_watchdog`: load/enable counter with an expired flag, instantiated only under the macro.
- Everything else is a single FSM plus datapath registers.

## Test plan
- Add 0x02+0x03 (op 00):
  - `alu_begin` pulses once, then `alu_in` shows 0x02 followed by 0x03.
  - Stubbed `alu_end` with 0x05 gives `result`=0x0005 and one `done` pulse.
- Mul 0xC5×0x04 (op 10): the stub returns 0x03 then 0x14 → `result`=0x0314; `busy` stays high throughout.
- Div, a=0x31, b=0x12, c=0x7B (op 11):
  - Three bytes are serialised.
  - The stub returns quotient 0x66 and remainder 0x10 → `result`=0x6610.
- `start` re-asserted while `busy`, mid-SEND: no second `alu_begin`, and the operand bytes are unchanged.
- Timeout (macro on, `TIMEOUT_CYC`=8, stub never asserts `alu_end`):
  - `err` pulses 8 cycles after WAIT is entered, `busy`=0, `result` is unchanged.
  - With the macro off, the block stays in WAIT.
- `rst_n` pulsed low during RECV:
  - All outputs return to reset values asynchronously, with no `done`.
  - A following add completes normally.
